axibram_status_mem: RTL and testbench

Single-port 32-bit status memory that feeds the AXI BRAM read channel. Internal status sources write words through a small posted write queue. The AXI read master reads through a BRAM-style port with a 2-stage pipeline (`ren` then `regen`) and uses the `dev_ready` handshake. A write fence guarantees that every write accepted on or before the cycle of `start_burst` lands in memory before the burst's first data word is released.

---
 rtl/axibram_status_mem.sv | 140 ++++++++++++++
 tb/tb_axibram_status_mem.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axibram_status_mem.sv
// Single-port 32-bit status memory. Status writes go through a posted queue, and
// the AXI BRAM read side uses a 2-stage pipeline gated by a write fence.
module axibram_status_mem #(
  parameter int ADDRESS_BITS  = 10,
  parameter int WQ_DEPTH_LOG2 = 2
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDRESS_BITS-1:0] st_waddr,
  input  logic [31:0]             st_wdata,
  input  logic                    st_wvalid,
  output logic                    st_wready,
  input  logic                    start_burst,
  output logic                    dev_ready,
  input  logic [ADDRESS_BITS-1:0] bram_raddr,
  input  logic                    bram_ren,
  input  logic                    bram_regen,
  output logic [31:0]             bram_rdata
);

  localparam int QD    = 1 << WQ_DEPTH_LOG2;
  localparam int CW    = WQ_DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << ADDRESS_BITS;

  typedef enum logic [1:0] {READY, FENCE, SETTLE} state_t;

  logic [ADDRESS_BITS-1:0]  q_addr [QD];
  logic [31:0]              q_data [QD];
  logic [WQ_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]            q_cnt, fence_cnt, fence_cap;
  logic [1:0]               settle_cnt, settle_nxt;
  state_t                   state, state_nxt;
  logic                     push, pop, q_nempty, fence_active;
  logic                     grant_wr, grant_rd;
  logic [31:0]              mem [DEPTH];
  logic [31:0]              s1;

  assign st_wready    = (q_cnt != CW'(QD));
  assign push         = st_wvalid && st_wready;
  assign q_nempty     = (q_cnt != '0);
  assign fence_active = (fence_cnt != '0);
  assign grant_wr     = q_nempty && (!bram_ren || fence_active);
  assign grant_rd     = bram_ren && !grant_wr;
  assign pop          = grant_wr;
  // Count captured by a burst start: includes this cycle's push, excludes its pop
  assign fence_cap    = q_cnt + CW'(push) - CW'(pop);

  always_ff @(posedge aclk) begin
    if (push) begin
      q_addr[wr_ptr] <= st_waddr;
      q_data[wr_ptr] <= st_wdata;
    end
  end

  // Memory contents are deliberately not reset
  always_ff @(posedge aclk) begin
    if (grant_wr) begin
      mem[q_addr[rd_ptr]] <= q_data[rd_ptr];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + WQ_DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + WQ_DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + CW'(1);
        2'b01:   q_cnt <= q_cnt - CW'(1);
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fence_cnt <= '0;
    end else if (start_burst) begin
      fence_cnt <= fence_cap;
    end else if (grant_wr && fence_active) begin
      fence_cnt <= fence_cnt - CW'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= READY;
      settle_cnt <= '0;
      dev_ready  <= 1'b1;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      dev_ready  <= (state_nxt == READY);
    end
  end

  // A fence recaptured with zero count falls through to SETTLE on the next cycle
  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    case (state)
      READY: begin
        if (start_burst && fence_cap != '0) state_nxt = FENCE;
      end
      FENCE: begin
        if (start_burst) begin
          state_nxt = FENCE;
        end else if (!fence_active || (grant_wr && fence_cnt == CW'(1))) begin
          state_nxt  = SETTLE;
          settle_nxt = 2'd2;
        end
      end
      SETTLE: begin
        if (start_burst && fence_cap != '0) begin
          state_nxt = FENCE;
        end else if (settle_cnt <= 2'd1) begin
          state_nxt  = READY;
          settle_nxt = 2'd0;
        end else begin
          settle_nxt = settle_cnt - 2'd1;
        end
      end
      default: state_nxt = READY;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1         <= '0;
      bram_rdata <= '0;
    end else begin
      if (grant_rd)   s1         <= mem[bram_raddr];
      if (bram_regen) bram_rdata <= s1;
    end
  end

endmodule

// File: tb/tb_axibram_status_mem.sv
// Directed self-checking bench for axibram_status_mem: readback table plus
// hand-written fence, backpressure and reset sequences.
module tb_axibram_status_mem;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [9:0]  st_waddr;
  logic [31:0] st_wdata;
  logic        st_wvalid;
  logic        st_wready;
  logic        start_burst;
  logic        dev_ready;
  logic [9:0]  bram_raddr;
  logic        bram_ren;
  logic        bram_regen;
  logic [31:0] bram_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  axibram_status_mem dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .st_waddr    (st_waddr),
    .st_wdata    (st_wdata),
    .st_wvalid   (st_wvalid),
    .st_wready   (st_wready),
    .start_burst (start_burst),
    .dev_ready   (dev_ready),
    .bram_raddr  (bram_raddr),
    .bram_ren    (bram_ren),
    .bram_regen  (bram_regen),
    .bram_rdata  (bram_rdata)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Push one write, waiting a bounded number of cycles for the queue to accept it
  task automatic applyStimulus(input logic [9:0] a, input logic [31:0] d);
    st_waddr  = a;
    st_wdata  = d;
    st_wvalid = 1'b1;
    for (int i = 0; i < 20 && !st_wready; i++) tick();
    if (!st_wready) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL push_timeout: st_wready got 0, expected 1");
    end
    tick();
    st_wvalid = 1'b0;
  endtask

  task automatic readWord(input logic [9:0] a, output logic [31:0] d);
    bram_raddr = a;
    bram_ren   = 1'b1;
    bram_regen = 1'b0;
    tick();
    bram_ren   = 1'b0;
    bram_regen = 1'b1;
    tick();
    bram_regen = 1'b0;
    d = bram_rdata;
  endtask

  initial begin
    logic [31:0] rd;

    vecs[0] = '{addr: 10'd5,    data: 32'h0000_0011, exp: 32'h0000_0055};
    vecs[1] = '{addr: 10'd6,    data: 32'h0000_0022, exp: 32'h0000_0022};
    vecs[2] = '{addr: 10'd7,    data: 32'h0000_0033, exp: 32'h0000_0033};
    vecs[3] = '{addr: 10'd0,    data: 32'hA5A5_0000, exp: 32'hA5A5_0000};
    vecs[4] = '{addr: 10'd1023, data: 32'hFFFF_FFFF, exp: 32'hFFFF_FFFF};
    vecs[5] = '{addr: 10'd5,    data: 32'h0000_0055, exp: 32'h0000_0055};

    aresetn     = 1'b0;
    st_waddr    = '0;
    st_wdata    = '0;
    st_wvalid   = 1'b0;
    start_burst = 1'b0;
    bram_raddr  = '0;
    bram_ren    = 1'b0;
    bram_regen  = 1'b0;
    repeat (3) tick();
    aresetn = 1'b1;
    tick();

    // Reset values under random inputs, memory retained across reset
    applyStimulus(10'd3, 32'hDEAD_0003);
    repeat (2) tick();
    aresetn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st_waddr    = 10'($urandom);
      st_wdata    = $urandom;
      st_wvalid   = 1'($urandom);
      start_burst = 1'($urandom);
      bram_raddr  = 10'($urandom);
      bram_ren    = 1'($urandom);
      bram_regen  = 1'($urandom);
      tick();
      checkOutput("reset_st_wready", 32'(st_wready), 32'd1);
      checkOutput("reset_dev_ready", 32'(dev_ready), 32'd1);
      checkOutput("reset_bram_rdata", bram_rdata, 32'd0);
    end
    st_wvalid   = 1'b0;
    start_burst = 1'b0;
    bram_ren    = 1'b0;
    bram_regen  = 1'b0;
    aresetn     = 1'b1;
    tick();
    readWord(10'd3, rd);
    checkOutput("mem_kept_through_reset", rd, 32'hDEAD_0003);

    // Idle drain and table-driven readback
    foreach (vecs[i]) applyStimulus(vecs[i].addr, vecs[i].data);
    tick();
    checkOutput("idle_drain_q_cnt", 32'(dut.q_cnt), 32'd0);
    foreach (vecs[i]) begin
      readWord(vecs[i].addr, rd);
      checkOutput($sformatf("readback_%0d", i), rd, vecs[i].exp);
    end

    // Full-queue backpressure while reads hold the port
    bram_ren   = 1'b1;
    bram_raddr = 10'd0;
    st_wvalid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      st_waddr = 10'(20 + i);
      st_wdata = 32'h1000_0000 + 32'(i);
      tick();
    end
    st_waddr = 10'd24;
    st_wdata = 32'h0005_5555;
    checkOutput("full_q_cnt", 32'(dut.q_cnt), 32'd4);
    checkOutput("full_st_wready", 32'(st_wready), 32'd0);
    tick();
    checkOutput("full_held_q_cnt", 32'(dut.q_cnt), 32'd4);
    checkOutput("full_held_st_wready", 32'(st_wready), 32'd0);
    bram_ren = 1'b0;
    tick();
    checkOutput("first_pop_q_cnt", 32'(dut.q_cnt), 32'd3);
    checkOutput("first_pop_st_wready", 32'(st_wready), 32'd1);
    tick();
    st_wvalid = 1'b0;
    checkOutput("push_pop_q_cnt", 32'(dut.q_cnt), 32'd3);
    repeat (3) tick();
    checkOutput("full_drained_q_cnt", 32'(dut.q_cnt), 32'd0);
    readWord(10'd20, rd);
    checkOutput("full_readback_20", rd, 32'h1000_0000);
    readWord(10'd24, rd);
    checkOutput("full_readback_24", rd, 32'h0005_5555);

    // Fence with two queued writes, reads held high
    bram_ren   = 1'b1;
    bram_raddr = 10'd9;
    bram_regen = 1'b1;
    applyStimulus(10'd9, 32'h0000_00AA);
    applyStimulus(10'd10, 32'h0000_00BB);
    checkOutput("fence_pre_dev_ready", 32'(dev_ready), 32'd1);
    start_burst = 1'b1;
    tick();
    start_burst = 1'b0;
    checkOutput("fence_start_dev_ready", 32'(dev_ready), 32'd0);
    checkOutput("fence_start_cnt", 32'(dut.fence_cnt), 32'd2);
    tick();
    checkOutput("fence_drain1_q_cnt", 32'(dut.q_cnt), 32'd1);
    checkOutput("fence_drain1_dev_ready", 32'(dev_ready), 32'd0);
    tick();
    checkOutput("fence_drain2_q_cnt", 32'(dut.q_cnt), 32'd0);
    checkOutput("fence_drain2_dev_ready", 32'(dev_ready), 32'd0);
    tick();
    checkOutput("fence_settle_dev_ready", 32'(dev_ready), 32'd0);
    tick();
    checkOutput("fence_done_dev_ready", 32'(dev_ready), 32'd1);
    checkOutput("fence_post_rdata", bram_rdata, 32'h0000_00AA);
    bram_regen = 1'b0;
    bram_ren   = 1'b0;
    tick();
    readWord(10'd10, rd);
    checkOutput("fence_readback_10", rd, 32'h0000_00BB);

    // Fence membership: start-cycle push fenced, next-cycle push not
    bram_ren   = 1'b1;
    bram_raddr = 10'd30;
    applyStimulus(10'd40, 32'h0000_0040);
    st_waddr    = 10'd41;
    st_wdata    = 32'h0000_0041;
    st_wvalid   = 1'b1;
    start_burst = 1'b1;
    tick();
    start_burst = 1'b0;
    checkOutput("member_fence_cnt", 32'(dut.fence_cnt), 32'd2);
    st_waddr = 10'd42;
    st_wdata = 32'h0000_0042;
    tick();
    st_wvalid = 1'b0;
    checkOutput("member_late_q_cnt", 32'(dut.q_cnt), 32'd2);
    checkOutput("member_late_fence_cnt", 32'(dut.fence_cnt), 32'd1);
    tick();
    checkOutput("member_last_drain_q_cnt", 32'(dut.q_cnt), 32'd1);
    checkOutput("member_last_drain_fence", 32'(dut.fence_cnt), 32'd0);
    tick();
    checkOutput("member_settle_dev_ready", 32'(dev_ready), 32'd0);
    tick();
    checkOutput("member_ready_dev_ready", 32'(dev_ready), 32'd1);
    checkOutput("member_unfenced_held", 32'(dut.q_cnt), 32'd1);
    bram_ren = 1'b0;
    tick();
    checkOutput("member_unfenced_drained", 32'(dut.q_cnt), 32'd0);
    readWord(10'd42, rd);
    checkOutput("member_readback_42", rd, 32'h0000_0042);
    readWord(10'd41, rd);
    checkOutput("member_readback_41", rd, 32'h0000_0041);

    // Reset asserted mid-fence: queued writes are lost, memory untouched
    applyStimulus(10'd50, 32'h0000_0500);
    applyStimulus(10'd51, 32'h0000_0510);
    applyStimulus(10'd52, 32'h0000_0520);
    repeat (2) tick();
    bram_ren   = 1'b1;
    bram_raddr = 10'd0;
    applyStimulus(10'd50, 32'h0000_BAD0);
    applyStimulus(10'd51, 32'h0000_BAD1);
    applyStimulus(10'd52, 32'h0000_BAD2);
    start_burst = 1'b1;
    tick();
    start_burst = 1'b0;
    checkOutput("rstfence_dev_ready_low", 32'(dev_ready), 32'd0);
    checkOutput("rstfence_fence_cnt", 32'(dut.fence_cnt), 32'd3);
    aresetn = 1'b0;
    #1;
    checkOutput("rstfence_dev_ready_async", 32'(dev_ready), 32'd1);
    checkOutput("rstfence_q_cnt_async", 32'(dut.q_cnt), 32'd0);
    checkOutput("rstfence_st_wready_async", 32'(st_wready), 32'd1);
    bram_ren = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
    readWord(10'd50, rd);
    checkOutput("rstfence_keep_50", rd, 32'h0000_0500);
    readWord(10'd51, rd);
    checkOutput("rstfence_keep_51", rd, 32'h0000_0510);
    readWord(10'd52, rd);
    checkOutput("rstfence_keep_52", rd, 32'h0000_0520);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
